// File: rtl/mbus_tx_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mbus_tx_sequencer_pkg
// Description : Shared widths, FSM state encoding and FIFO entry layouts for
//               the MBus transmit sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package mbus_tx_sequencer_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_REQ    = 3'd2,
        ST_DROP   = 3'd3,
        ST_RESULT = 3'd4,
        ST_RESP   = 3'd5,
        ST_DRAIN  = 3'd6
    } tx_state_e;

    // Word FIFO entry: end-of-message flag travels with each data word
    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } word_t;

    // Message queue entry: destination and priority of one complete message
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  prio;
    } msg_t;

endpackage
`default_nettype wire

// File: rtl/mbus_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mbus_sync_fifo
// Description : Single-clock FIFO with wrap-bit pointers. Full/count derive
//               only from registered pointers, so a same-cycle pop never
//               frees space early.
// Revision    : 1.0 - initial release
// ============================================================================
module mbus_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_IDX_W = $clog2(DEPTH);

    logic [c_IDX_W:0]  r_wptr;
    logic [c_IDX_W:0]  r_rptr;
    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic              w_empty;
    logic              w_do_push;
    logic              w_do_pop;

    assign w_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[c_IDX_W] != r_rptr[c_IDX_W]) &&
                       (r_wptr[c_IDX_W-1:0] == r_rptr[c_IDX_W-1:0]);
    assign o_count   = r_wptr - r_rptr;
    assign o_data    = r_mem[r_rptr[c_IDX_W-1:0]];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !w_empty;

    // Advance read/write pointers; reset empties the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage array write port
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[c_IDX_W-1:0]] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/mbus_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mbus_tx_sequencer
// Description : Buffers host messages and plays them word by word into the
//               MBus node TX handshake, then closes each message with the
//               SUCC/FAIL/RESP_ACK exchange and reports status to the host.
// Revision    : 1.0 - initial release
// ============================================================================
module mbus_tx_sequencer
    import mbus_tx_sequencer_pkg::*;
#(
    parameter int          WORD_DEPTH  = 16,
    parameter int          MSG_DEPTH   = 4,
    parameter logic [15:0] ACK_TIMEOUT = 16'hFFFF
) (
    input  logic                          CLK_EXT,
    input  logic                          RESETn,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          wr_last,
    input  logic [ADDR_WIDTH-1:0]         wr_addr,
    input  logic                          wr_priority,
    output logic [ADDR_WIDTH-1:0]         TX_ADDR,
    output logic [DATA_WIDTH-1:0]         TX_DATA,
    output logic                          TX_REQ,
    output logic                          TX_PEND,
    output logic                          TX_PRIORITY,
    input  logic                          TX_ACK,
    input  logic                          TX_SUCC,
    input  logic                          TX_FAIL,
    output logic                          TX_RESP_ACK,
    output logic                          busy,
    output logic                          done,
    output logic                          done_fail,
    output logic [$clog2(MSG_DEPTH):0]    msg_count
);

    tx_state_e                      r_state;
    logic                           r_fail;
    logic                           r_last;
    logic                           r_drain;
    logic [15:0]                    r_timer;

    word_t                          w_word_head;
    msg_t                           w_msg_head;
    logic                           w_word_full;
    logic                           w_msg_full;
    logic [$clog2(WORD_DEPTH):0]    w_word_count;
    logic                           w_push;
    logic                           w_word_empty;
    logic                           w_msg_empty;
    logic                           w_word_pop;
    logic                           w_msg_pop;
    logic                           w_timeout;
    logic                           w_abort;
    logic                           w_abort_drain;

    // A last word needs room in both queues; full flags are registered
    assign wr_ready     = !w_word_full && (!wr_last || !w_msg_full);
    assign w_push       = wr_valid && wr_ready;
    assign w_word_empty = (w_word_count == '0);
    assign w_msg_empty  = (msg_count == '0);
    assign busy         = (r_state != ST_IDLE);

    mbus_sync_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (WORD_DEPTH)
    ) u_word_fifo (
        .clk     (CLK_EXT),
        .rst_n   (RESETn),
        .i_push  (w_push),
        .i_data  ({wr_last, wr_data}),
        .i_pop   (w_word_pop),
        .o_data  (w_word_head),
        .o_full  (w_word_full),
        .o_count (w_word_count)
    );

    mbus_sync_fifo #(
        .WIDTH (ADDR_WIDTH + 1),
        .DEPTH (MSG_DEPTH)
    ) u_msg_fifo (
        .clk     (CLK_EXT),
        .rst_n   (RESETn),
        .i_push  (w_push && wr_last),
        .i_data  ({wr_addr, wr_priority}),
        .i_pop   (w_msg_pop),
        .o_data  (w_msg_head),
        .o_full  (w_msg_full),
        .o_count (msg_count)
    );

    // Pop strobes and abort detection (node FAIL or watchdog while mid-word)
    always_comb begin
        w_timeout     = (r_timer == 16'd0);
        w_abort       = ((r_state == ST_REQ) || (r_state == ST_DROP)) &&
                        (TX_FAIL || w_timeout);
        // In REQ the current word is still queued; in DROP it is already gone
        w_abort_drain = (r_state == ST_REQ) || !r_last;
        w_msg_pop     = (r_state == ST_IDLE) && !w_msg_empty;
        w_word_pop    = ((r_state == ST_REQ) && TX_ACK && !w_abort) ||
                        ((r_state == ST_DRAIN) && !w_word_empty);
    end

    // Transmit sequencing FSM with registered node/host outputs
    always_ff @(posedge CLK_EXT or negedge RESETn) begin
        if (!RESETn) begin
            r_state     <= ST_IDLE;
            r_fail      <= 1'b0;
            r_last      <= 1'b0;
            r_drain     <= 1'b0;
            r_timer     <= ACK_TIMEOUT;
            TX_ADDR     <= '0;
            TX_DATA     <= '0;
            TX_REQ      <= 1'b0;
            TX_PEND     <= 1'b0;
            TX_PRIORITY <= 1'b0;
            TX_RESP_ACK <= 1'b0;
            done        <= 1'b0;
            done_fail   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (r_timer != 16'd0) r_timer <= r_timer - 16'd1;

            if (w_abort) begin
                TX_REQ  <= 1'b0;
                TX_PEND <= 1'b0;
                r_fail  <= 1'b1;
                r_drain <= w_abort_drain;
                r_timer <= ACK_TIMEOUT;
                if (TX_FAIL || TX_SUCC) begin
                    TX_RESP_ACK <= 1'b1;
                    r_state     <= ST_RESP;
                end else if (w_abort_drain) begin
                    r_state <= ST_DRAIN;
                end else begin
                    done      <= 1'b1;
                    done_fail <= 1'b1;
                    r_state   <= ST_IDLE;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_msg_pop) begin
                            TX_ADDR     <= w_msg_head.addr;
                            TX_PRIORITY <= w_msg_head.prio;
                            TX_DATA     <= w_word_head.data;
                            TX_PEND     <= !w_word_head.last;
                            r_last      <= w_word_head.last;
                            r_state     <= ST_LOAD;
                            r_timer     <= ACK_TIMEOUT;
                        end
                    end
                    ST_LOAD: begin
                        TX_REQ  <= 1'b1;
                        r_state <= ST_REQ;
                        r_timer <= ACK_TIMEOUT;
                    end
                    ST_REQ: begin
                        if (TX_ACK) begin
                            TX_REQ  <= 1'b0;
                            r_state <= ST_DROP;
                            r_timer <= ACK_TIMEOUT;
                        end
                    end
                    ST_DROP: begin
                        if (!TX_ACK) begin
                            r_timer <= ACK_TIMEOUT;
                            if (r_last) begin
                                r_state <= ST_RESULT;
                            end else begin
                                TX_DATA <= w_word_head.data;
                                TX_PEND <= !w_word_head.last;
                                r_last  <= w_word_head.last;
                                r_state <= ST_LOAD;
                            end
                        end
                    end
                    ST_RESULT: begin
                        if (TX_SUCC || TX_FAIL) begin
                            r_fail      <= TX_FAIL;
                            r_drain     <= 1'b0;
                            TX_RESP_ACK <= 1'b1;
                            r_state     <= ST_RESP;
                            r_timer     <= ACK_TIMEOUT;
                        end else if (w_timeout) begin
                            done      <= 1'b1;
                            done_fail <= 1'b1;
                            r_state   <= ST_IDLE;
                            r_timer   <= ACK_TIMEOUT;
                        end
                    end
                    ST_RESP: begin
                        if (!TX_SUCC && !TX_FAIL) begin
                            TX_RESP_ACK <= 1'b0;
                            r_timer     <= ACK_TIMEOUT;
                            if (r_drain) begin
                                r_state <= ST_DRAIN;
                            end else begin
                                done      <= 1'b1;
                                done_fail <= r_fail;
                                r_state   <= ST_IDLE;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        // Discard the rest of the failed message, one word per cycle
                        if (w_word_empty || w_word_head.last) begin
                            done      <= 1'b1;
                            done_fail <= 1'b1;
                            r_state   <= ST_IDLE;
                            r_timer   <= ACK_TIMEOUT;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_timer <= ACK_TIMEOUT;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mbus_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mbus_tx_sequencer
// Description : Self-checking bench for mbus_tx_sequencer. Expected node-side
//               words and completion statuses are queued as stimulus is
//               written and checked as the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mbus_tx_sequencer;
    import mbus_tx_sequencer_pkg::*;

    localparam int          TB_TIMEOUT = 64;

    logic                    CLK_EXT = 1'b0;
    logic                    RESETn  = 1'b0;
    logic                    wr_valid = 1'b0;
    logic                    wr_ready;
    logic [DATA_WIDTH-1:0]   wr_data = '0;
    logic                    wr_last = 1'b0;
    logic [ADDR_WIDTH-1:0]   wr_addr = '0;
    logic                    wr_priority = 1'b0;
    logic [ADDR_WIDTH-1:0]   TX_ADDR;
    logic [DATA_WIDTH-1:0]   TX_DATA;
    logic                    TX_REQ;
    logic                    TX_PEND;
    logic                    TX_PRIORITY;
    logic                    TX_ACK = 1'b0;
    logic                    TX_SUCC = 1'b0;
    logic                    TX_FAIL = 1'b0;
    logic                    TX_RESP_ACK;
    logic                    busy;
    logic                    done;
    logic                    done_fail;
    logic [2:0]              msg_count;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        pend;
        logic        prio;
    } exp_word_t;

    exp_word_t exp_word_q[$];
    bit        exp_done_q[$];
    int        total = 0;
    int        bad   = 0;

    mbus_tx_sequencer #(
        .WORD_DEPTH  (16),
        .MSG_DEPTH   (4),
        .ACK_TIMEOUT (16'(TB_TIMEOUT))
    ) dut (
        .CLK_EXT     (CLK_EXT),
        .RESETn      (RESETn),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .wr_last     (wr_last),
        .wr_addr     (wr_addr),
        .wr_priority (wr_priority),
        .TX_ADDR     (TX_ADDR),
        .TX_DATA     (TX_DATA),
        .TX_REQ      (TX_REQ),
        .TX_PEND     (TX_PEND),
        .TX_PRIORITY (TX_PRIORITY),
        .TX_ACK      (TX_ACK),
        .TX_SUCC     (TX_SUCC),
        .TX_FAIL     (TX_FAIL),
        .TX_RESP_ACK (TX_RESP_ACK),
        .busy        (busy),
        .done        (done),
        .done_fail   (done_fail),
        .msg_count   (msg_count)
    );

    always #5 CLK_EXT = ~CLK_EXT;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor: word presentation, REQ stability and completions
    initial begin
        logic        req_prev;
        logic [32:0] held;
        exp_word_t   e;
        bit          ef;
        req_prev = 1'b0;
        held     = '0;
        forever begin
            @(negedge CLK_EXT);
            if (!RESETn) begin
                req_prev = 1'b0;
            end else begin
                if (TX_REQ === 1'b1 && !req_prev) begin
                    total++;
                    if (TX_ACK !== 1'b0) begin
                        bad++;
                        $display("FAIL req_after_ack: TX_ACK=%b at TX_REQ rise, want 0", TX_ACK);
                    end
                    total++;
                    if (exp_word_q.size() == 0) begin
                        bad++;
                        $display("FAIL tx_word: unexpected word addr=%h data=%h", TX_ADDR, TX_DATA);
                    end else begin
                        e = exp_word_q.pop_front();
                        if ({TX_ADDR, TX_DATA, TX_PEND, TX_PRIORITY} !== {e.addr, e.data, e.pend, e.prio}) begin
                            bad++;
                            $display("FAIL tx_word: got addr=%h data=%h pend=%b prio=%b, want addr=%h data=%h pend=%b prio=%b",
                                     TX_ADDR, TX_DATA, TX_PEND, TX_PRIORITY, e.addr, e.data, e.pend, e.prio);
                        end
                    end
                    held = {TX_DATA, TX_PEND};
                end else if (TX_REQ === 1'b1) begin
                    total++;
                    if ({TX_DATA, TX_PEND} !== held) begin
                        bad++;
                        $display("FAIL req_stable: got data/pend=%h, want %h", {TX_DATA, TX_PEND}, held);
                    end
                end
                if (done === 1'b1) begin
                    total++;
                    if (exp_done_q.size() == 0) begin
                        bad++;
                        $display("FAIL done_status: unexpected done pulse, done_fail=%b", done_fail);
                    end else begin
                        ef = exp_done_q.pop_front();
                        if (done_fail !== ef) begin
                            bad++;
                            $display("FAIL done_status: got done_fail=%b, want %b", done_fail, ef);
                        end
                    end
                end
                req_prev = TX_REQ;
            end
        end
    end

    function automatic logic pick(input int sel);
        case (sel)
            0:       return TX_REQ;
            1:       return TX_RESP_ACK;
            2:       return done;
            default: return busy;
        endcase
    endfunction

    // Wait (at negedges) until the selected signal reaches val, bounded
    task automatic wait_level(input int sel, input logic val, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (pick(sel) === val) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLK_EXT);
        end
    endtask

    // Host write of one word; returns at the negedge after acceptance
    task automatic host_write(input logic [31:0] d, input logic last, input logic [31:0] a,
                              input logic p, output bit ok);
        wr_data = d; wr_last = last; wr_addr = a; wr_priority = p; wr_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (wr_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLK_EXT);
        end
        if (ok) begin
            @(posedge CLK_EXT);
            @(negedge CLK_EXT);
        end
        wr_valid = 1'b0; wr_last = 1'b0;
    endtask

    // Node-side word handshake; optionally raises TX_FAIL once REQ drops
    task automatic node_ack(input int delay, input bit fail_now, output bit ok, output logic req_after);
        req_after = 1'bx;
        wait_level(0, 1'b1, 200, ok);
        if (!ok) return;
        repeat (delay) @(negedge CLK_EXT);
        TX_ACK = 1'b1;
        @(negedge CLK_EXT);
        req_after = TX_REQ;
        TX_ACK = 1'b0;
        if (fail_now) TX_FAIL = 1'b1;
    endtask

    // Node-side result exchange; returns on the negedge RESP_ACK falls
    task automatic node_result(input bit fail, output bit ok);
        if (fail) TX_FAIL = 1'b1; else TX_SUCC = 1'b1;
        wait_level(1, 1'b1, 50, ok);
        TX_SUCC = 1'b0; TX_FAIL = 1'b0;
        if (ok) wait_level(1, 1'b0, 50, ok);
    endtask

    task automatic do_reset();
        @(negedge CLK_EXT);
        RESETn = 1'b0;
        wr_valid = 1'b0; wr_last = 1'b0; TX_ACK = 1'b0; TX_SUCC = 1'b0; TX_FAIL = 1'b0;
        exp_word_q.delete();
        exp_done_q.delete();
        repeat (2) @(negedge CLK_EXT);
        RESETn = 1'b1;
        @(negedge CLK_EXT);
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({TX_REQ, TX_PEND, TX_RESP_ACK, TX_PRIORITY} !== 4'b0) begin
            bad++; $display("FAIL reset_tx_ctrl: got %b, want 0000", {TX_REQ, TX_PEND, TX_RESP_ACK, TX_PRIORITY});
        end
        total++;
        if ({busy, done, done_fail, msg_count} !== 6'b0) begin
            bad++; $display("FAIL reset_status: got %b, want 000000", {busy, done, done_fail, msg_count});
        end
        total++;
        if (wr_ready !== 1'b1) begin
            bad++; $display("FAIL reset_wr_ready: got %b, want 1", wr_ready);
        end
        total++;
        if ({TX_ADDR, TX_DATA} !== 64'h0) begin
            bad++; $display("FAIL reset_tx_bus: got %h, want 0", {TX_ADDR, TX_DATA});
        end
        @(negedge CLK_EXT);
        RESETn = 1'b1;
        @(negedge CLK_EXT);
    endtask

    task automatic test_single();
        bit ok; logic ra;
        exp_word_q.push_back('{addr: 32'h0000_0015, data: 32'hDEADBEEF, pend: 1'b0, prio: 1'b0});
        exp_done_q.push_back(1'b0);
        host_write(32'hDEADBEEF, 1'b1, 32'h0000_0015, 1'b0, ok);
        total++;
        if (!ok || msg_count !== 3'd1) begin
            bad++; $display("FAIL single_queued: ok=%b msg_count=%0d, want 1", ok, msg_count);
        end
        @(negedge CLK_EXT);
        total++;
        if (msg_count !== 3'd0 || busy !== 1'b1 || TX_REQ !== 1'b0) begin
            bad++; $display("FAIL single_load: msg_count=%0d busy=%b req=%b, want 0 1 0", msg_count, busy, TX_REQ);
        end
        @(negedge CLK_EXT);
        total++;
        if (TX_REQ !== 1'b1) begin
            bad++; $display("FAIL single_latency: TX_REQ=%b two cycles after queueing, want 1", TX_REQ);
        end
        node_ack(3, 1'b0, ok, ra);
        total++;
        if (!ok || ra !== 1'b0) begin
            bad++; $display("FAIL single_req_drop: ok=%b TX_REQ=%b one cycle after ACK, want 0", ok, ra);
        end
        node_result(1'b0, ok);
        total++;
        if (!ok || done !== 1'b1 || done_fail !== 1'b0) begin
            bad++; $display("FAIL single_done: ok=%b done=%b done_fail=%b, want 1 0", ok, done, done_fail);
        end
        @(negedge CLK_EXT);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL single_idle: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_multi_word();
        bit ok, wok; logic ra;
        logic [31:0] words [3];
        words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
        wok = 1'b1;
        for (int i = 0; i < 3; i++)
            exp_word_q.push_back('{addr: 32'h0000_00A2, data: words[i], pend: (i != 2), prio: 1'b1});
        exp_done_q.push_back(1'b0);
        for (int i = 0; i < 3; i++) begin
            host_write(words[i], (i == 2), 32'h0000_00A2, 1'b1, ok);
            wok &= ok;
        end
        for (int i = 0; i < 3; i++) begin
            node_ack((i == 1) ? 0 : 2, 1'b0, ok, ra);
            wok &= ok && (ra === 1'b0);
        end
        total++;
        if (!wok) begin
            bad++; $display("FAIL multi_handshake: write/ack sequence incomplete, got ok=%b want 1", wok);
        end
        node_result(1'b0, ok);
        total++;
        if (!ok || done !== 1'b1 || done_fail !== 1'b0) begin
            bad++; $display("FAIL multi_done: ok=%b done=%b done_fail=%b, want 1 0", ok, done, done_fail);
        end
        @(negedge CLK_EXT);
    endtask

    task automatic test_fail_drain();
        bit ok, wok; logic ra;
        wok = 1'b1;
        exp_word_q.push_back('{addr: 32'h33, data: 32'hA1, pend: 1'b1, prio: 1'b1});
        exp_word_q.push_back('{addr: 32'h33, data: 32'hA2, pend: 1'b1, prio: 1'b1});
        exp_word_q.push_back('{addr: 32'h44, data: 32'hB1, pend: 1'b0, prio: 1'b0});
        exp_done_q.push_back(1'b1);
        exp_done_q.push_back(1'b0);
        for (int i = 0; i < 4; i++) begin
            host_write(32'hA1 + i, (i == 3), 32'h33, 1'b1, ok);
            wok &= ok;
        end
        host_write(32'hB1, 1'b1, 32'h44, 1'b0, ok);
        wok &= ok;
        node_ack(2, 1'b0, ok, ra);
        wok &= ok;
        node_ack(1, 1'b1, ok, ra);
        wok &= ok;
        wait_level(1, 1'b1, 20, ok);
        total++;
        if (!wok || !ok || TX_REQ !== 1'b0 || TX_PEND !== 1'b0) begin
            bad++; $display("FAIL fail_resp: ok=%b/%b req=%b pend=%b, want RESP_ACK with req=0 pend=0", wok, ok, TX_REQ, TX_PEND);
        end
        TX_FAIL = 1'b0;
        wait_level(2, 1'b1, 20, ok);
        total++;
        if (!ok || done_fail !== 1'b1) begin
            bad++; $display("FAIL fail_done: ok=%b done_fail=%b, want done with done_fail=1", ok, done_fail);
        end
        node_ack(1, 1'b0, ok, ra);
        total++;
        if (!ok || done_fail !== 1'b1) begin
            bad++; $display("FAIL fail_hold: ok=%b done_fail=%b during next message, want 1", ok, done_fail);
        end
        node_result(1'b0, ok);
        total++;
        if (!ok || done !== 1'b1 || done_fail !== 1'b0) begin
            bad++; $display("FAIL followon_done: ok=%b done=%b done_fail=%b, want 1 0", ok, done, done_fail);
        end
        @(negedge CLK_EXT);
        total++;
        if (busy !== 1'b0 || msg_count !== 3'd0) begin
            bad++; $display("FAIL followon_idle: busy=%b msg_count=%0d, want 0 0", busy, msg_count);
        end
    endtask

    task automatic test_backpressure();
        bit ok, wok;
        wok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            host_write(32'hC00 + i, 1'b0, 32'h0, 1'b0, ok);
            wok &= ok;
        end
        wr_last = 1'b0; #1;
        total++;
        if (!wok || wr_ready !== 1'b0) begin
            bad++; $display("FAIL word_full: ok=%b wr_ready=%b after 16 words, want 0", wok, wr_ready);
        end
        wr_last = 1'b1; #1;
        total++;
        if (wr_ready !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL word_full_last: wr_ready=%b busy=%b, want 0 0", wr_ready, busy);
        end
        wr_last = 1'b0;
        do_reset();
        exp_word_q.push_back('{addr: 32'h50, data: 32'h500, pend: 1'b0, prio: 1'b0});
        wok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            host_write(32'h500 + i, 1'b1, 32'h50 + i, 1'b0, ok);
            wok &= ok;
        end
        total++;
        if (!wok || msg_count !== 3'd4) begin
            bad++; $display("FAIL msg_full_count: ok=%b msg_count=%0d, want 4", wok, msg_count);
        end
        wr_last = 1'b1; #1;
        total++;
        if (wr_ready !== 1'b0) begin
            bad++; $display("FAIL msg_full_last: wr_ready=%b, want 0", wr_ready);
        end
        wr_last = 1'b0; #1;
        total++;
        if (wr_ready !== 1'b1) begin
            bad++; $display("FAIL msg_full_nonlast: wr_ready=%b, want 1", wr_ready);
        end
        wr_valid = 1'b1; wr_last = 1'b1;
        @(negedge CLK_EXT);
        wr_valid = 1'b0; wr_last = 1'b0;
        total++;
        if (msg_count !== 3'd4) begin
            bad++; $display("FAIL msg_full_block: msg_count=%0d after blocked write, want 4", msg_count);
        end
        do_reset();
    endtask

    task automatic test_timeout();
        bit ok; int cyc; logic saw_resp;
        exp_word_q.push_back('{addr: 32'h77, data: 32'h7777, pend: 1'b0, prio: 1'b1});
        exp_done_q.push_back(1'b1);
        host_write(32'h7777, 1'b1, 32'h77, 1'b1, ok);
        wait_level(0, 1'b1, 20, ok);
        cyc = 0; saw_resp = 1'b0;
        while (ok && done !== 1'b1 && cyc < TB_TIMEOUT + 20) begin
            @(negedge CLK_EXT);
            cyc++;
            if (TX_RESP_ACK === 1'b1) saw_resp = 1'b1;
        end
        total++;
        if (!ok || done !== 1'b1 || cyc < TB_TIMEOUT || cyc > TB_TIMEOUT + 6 || saw_resp) begin
            bad++; $display("FAIL timeout_abort: ok=%b done=%b after %0d cycles resp=%b, want done in %0d..%0d cycles without resp",
                            ok, done, cyc, saw_resp, TB_TIMEOUT, TB_TIMEOUT + 6);
        end
        total++;
        if (busy !== 1'b0 || done_fail !== 1'b1 || TX_REQ !== 1'b0) begin
            bad++; $display("FAIL timeout_state: busy=%b done_fail=%b req=%b, want 0 1 0", busy, done_fail, TX_REQ);
        end
        @(negedge CLK_EXT);
    endtask

    task automatic test_reset_mid();
        bit ok, wok;
        exp_word_q.push_back('{addr: 32'h60, data: 32'h600, pend: 1'b0, prio: 1'b0});
        host_write(32'h600, 1'b1, 32'h60, 1'b0, wok);
        host_write(32'h601, 1'b1, 32'h61, 1'b0, ok);
        wok &= ok;
        wait_level(0, 1'b1, 20, ok);
        wok &= ok;
        #2;
        RESETn = 1'b0;
        exp_word_q.delete();
        exp_done_q.delete();
        #1;
        total++;
        if (!wok || TX_REQ !== 1'b0 || msg_count !== 3'd0 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_async: ok=%b req=%b msg_count=%0d busy=%b, want 0 0 0", wok, TX_REQ, msg_count, busy);
        end
        repeat (3) @(negedge CLK_EXT);
        RESETn = 1'b1;
        repeat (6) @(negedge CLK_EXT);
        total++;
        if (busy !== 1'b0 || TX_REQ !== 1'b0 || wr_ready !== 1'b1) begin
            bad++; $display("FAIL reset_clean: busy=%b req=%b wr_ready=%b, want 0 0 1", busy, TX_REQ, wr_ready);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi_word();
        test_fail_drain();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        total++;
        if (exp_word_q.size() != 0 || exp_done_q.size() != 0) begin
            bad++; $display("FAIL leftover: %0d words %0d dones never seen, want 0 0", exp_word_q.size(), exp_done_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
